// File: rtl/pixel_uart_tx_if.sv
// Capture-side bundle for pixel_uart_tx: the pixel strobe going in and the UART/status signals coming out.
// The capture stage (or a bench) takes the master modport and the serializer takes the slave modport.
interface pixel_uart_tx_if #(
  parameter int PixelBitWidth = 16,
  parameter int FifoDepth     = 16
);
  localparam int LevelW = $clog2(FifoDepth) + 1;

  logic [PixelBitWidth-1:0] i_data;
  logic                     i_ready;
  logic                     o_tx;
  logic                     o_busy;
  logic                     o_overflow;
  logic [LevelW-1:0]        o_level;

  modport master (
    output i_data, i_ready,
    input  o_tx, o_busy, o_overflow, o_level
  );

  modport slave (
    input  i_data, i_ready,
    output o_tx, o_busy, o_overflow, o_level
  );
endinterface

// File: rtl/pixel_uart_tx.sv
// Pixel FIFO feeding a UART 8N1 transmitter. Each pixel is sent as PixelBitWidth/8 bytes, MSB byte first,
// and each byte is sent LSB bit first. Overflow is sticky, and the FIFO does not use first-word fall-through.
module pixel_uart_tx #(
  parameter int PixelBitWidth = 16,
  parameter int ClkFreq       = 50_000_000,
  parameter int BaudRate      = 115200,
  parameter int FifoDepth     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  pixel_uart_tx_if.slave   bus
);
  localparam int ClksPerBit = ClkFreq / BaudRate;
  localparam int NumBytes   = PixelBitWidth / 8;
  localparam int AddrW      = $clog2(FifoDepth);
  localparam int LevelW     = AddrW + 1;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam int ByteW      = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [PixelBitWidth-1:0] mem_q [FifoDepth];
  logic [AddrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]        level_q;
  logic                     overflow_q;

  state_e                   state_q;
  logic [PixelBitWidth-1:0] shift_q;
  logic [CntW-1:0]          cnt_q;
  logic [2:0]               bit_q;
  logic [ByteW-1:0]         byte_q;
  logic                     tx_q;

  logic       pop, full, push, drop, bit_done;
  logic [7:0] cur_byte;

  // The pop decision uses the registered level, so a word written this edge is not visible until the next edge.
  assign pop      = (state_q == IDLE) && (level_q != '0);
  assign full     = (level_q == LevelW'(FifoDepth));
  assign push     = bus.i_ready && (!full || pop);
  assign drop     = bus.i_ready && full && !pop;
  assign bit_done = (cnt_q == CntW'(ClksPerBit - 1));
  assign cur_byte = shift_q[PixelBitWidth-1 -: 8];

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (drop) overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            byte_q  <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            // Any remaining bytes of the same pixel go straight back to START, with no idle cycle in between.
            if (byte_q == ByteW'(NumBytes - 1)) begin
              state_q <= IDLE;
            end else begin
              byte_q  <= byte_q + ByteW'(1);
              shift_q <= shift_q << 8;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_tx       = tx_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_level    = level_q;
  assign bus.o_busy     = (state_q != IDLE) || (level_q != '0);
endmodule
